// File: rtl/mc_rd_pack_seq_if.sv
// Control/status bundle between the memory-controller read sequencer and its host.
// master drives requests and acks; slave is the sequencer.
interface mc_rd_pack_seq_if;
  logic [31:0] csc;
  logic        start;
  logic [2:0]  len;
  logic        beat_ack;
  logic        abort;
  logic        pack_le0;
  logic        pack_le1;
  logic        pack_le2;
  logic        dv;
  logic        done;
  logic        busy;
  logic [1:0]  beat_cnt;
  logic [2:0]  word_cnt;
  logic        stray_ack;

  modport master (
    output csc, start, len, beat_ack, abort,
    input  pack_le0, pack_le1, pack_le2, dv, done, busy, beat_cnt, word_cnt, stray_ack
  );

  modport slave (
    input  csc, start, len, beat_ack, abort,
    output pack_le0, pack_le1, pack_le2, dv, done, busy, beat_cnt, word_cnt, stray_ack
  );
endinterface

// File: rtl/mc_rd_pack_seq.sv
// Read pack sequencer: counts bus beats per word for 8/16/32-bit chip selects and
// issues registered byte/half pack-latch enables plus a full-word valid strobe.
module mc_rd_pack_seq (
  input  logic              clk,
  input  logic              rst,
  mc_rd_pack_seq_if.slave   bus
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [1:0]  bw_q, bw_d;
  logic [2:0]  len_q, len_d;
  logic [1:0]  beat_cnt_q, beat_cnt_d;
  logic [2:0]  word_cnt_q, word_cnt_d;
  logic        pack_le0_q, pack_le0_d;
  logic        pack_le1_q, pack_le1_d;
  logic        pack_le2_q, pack_le2_d;
  logic        dv_q, dv_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        stray_ack_q, stray_ack_d;
  logic [1:0]  last_beat;

  wire unused_csc = &{1'b0, bus.csc[31:6], bus.csc[3:0]};

  always_comb begin
    case (bw_q)
      2'b00:   last_beat = 2'd3;
      2'b01:   last_beat = 2'd1;
      default: last_beat = 2'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    bw_d        = bw_q;
    len_d       = len_q;
    beat_cnt_d  = beat_cnt_q;
    word_cnt_d  = word_cnt_q;
    pack_le0_d  = 1'b0;
    pack_le1_d  = 1'b0;
    pack_le2_d  = 1'b0;
    dv_d        = 1'b0;
    done_d      = 1'b0;
    stray_ack_d = 1'b0;

    if (bus.abort) begin
      state_d    = IDLE;
      beat_cnt_d = '0;
      word_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          stray_ack_d = bus.beat_ack;
          if (bus.start) begin
            state_d    = ACTIVE;
            bw_d       = bus.csc[5:4];
            len_d      = bus.len;
            beat_cnt_d = '0;
            word_cnt_d = '0;
          end
        end
        ACTIVE: begin
          if (bus.beat_ack) begin
            // Beat index selects which lane latch fires; the final beat of a word is always dv.
            if (beat_cnt_q == last_beat) begin
              dv_d = 1'b1;
            end else begin
              case (beat_cnt_q)
                2'd0:    pack_le0_d = 1'b1;
                2'd1:    pack_le1_d = 1'b1;
                default: pack_le2_d = 1'b1;
              endcase
            end
            if (beat_cnt_q == last_beat) begin
              beat_cnt_d = '0;
              word_cnt_d = word_cnt_q + 3'd1;
              if (word_cnt_q == len_q) begin
                done_d  = 1'b1;
                state_d = IDLE;
              end
            end else begin
              beat_cnt_d = beat_cnt_q + 2'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d == ACTIVE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      bw_q        <= '0;
      len_q       <= '0;
      beat_cnt_q  <= '0;
      word_cnt_q  <= '0;
      pack_le0_q  <= 1'b0;
      pack_le1_q  <= 1'b0;
      pack_le2_q  <= 1'b0;
      dv_q        <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      stray_ack_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bw_q        <= bw_d;
      len_q       <= len_d;
      beat_cnt_q  <= beat_cnt_d;
      word_cnt_q  <= word_cnt_d;
      pack_le0_q  <= pack_le0_d;
      pack_le1_q  <= pack_le1_d;
      pack_le2_q  <= pack_le2_d;
      dv_q        <= dv_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      stray_ack_q <= stray_ack_d;
    end
  end

  assign bus.pack_le0  = pack_le0_q;
  assign bus.pack_le1  = pack_le1_q;
  assign bus.pack_le2  = pack_le2_q;
  assign bus.dv        = dv_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.beat_cnt  = beat_cnt_q;
  assign bus.word_cnt  = word_cnt_q;
  assign bus.stray_ack = stray_ack_q;

endmodule

// File: tb/tb_mc_rd_pack_seq.sv
// Table-driven bench for mc_rd_pack_seq: each row drives one cycle of inputs and
// queues the outputs expected after the next rising edge.
module tb_mc_rd_pack_seq;

  logic clk;
  logic rst;
  mc_rd_pack_seq_if bus();

  mc_rd_pack_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected strobe vector order: {pack_le0, pack_le1, pack_le2, dv, done, busy, stray_ack}
  localparam logic [6:0] S_IDLE  = 7'b0000000;
  localparam logic [6:0] S_BUSY  = 7'b0000010;
  localparam logic [6:0] S_LE0   = 7'b1000010;
  localparam logic [6:0] S_LE1   = 7'b0100010;
  localparam logic [6:0] S_LE2   = 7'b0010010;
  localparam logic [6:0] S_DV    = 7'b0001010;
  localparam logic [6:0] S_DONE  = 7'b0001100;
  localparam logic [6:0] S_STRAY = 7'b0000001;

  typedef struct {
    logic       start;
    logic       abort;
    logic       ack;
    logic [1:0] bw;
    logic [2:0] len;
    logic [6:0] exp_s;
    logic [1:0] exp_bc;
    logic [2:0] exp_wc;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   row_id   = 0;

  function automatic vec_t r(input logic st, input logic ab, input logic ak,
                             input logic [1:0] bw, input logic [2:0] ln,
                             input logic [6:0] es, input logic [1:0] bc,
                             input logic [2:0] wc);
    vec_t v;
    v.start = st; v.abort = ab; v.ack = ak; v.bw = bw; v.len = ln;
    v.exp_s = es; v.exp_bc = bc; v.exp_wc = wc;
    return v;
  endfunction

  function automatic logic [6:0] got_s();
    return {bus.pack_le0, bus.pack_le1, bus.pack_le2, bus.dv, bus.done, bus.busy, bus.stray_ack};
  endfunction

  task automatic check_outputs(input string tag);
    vec_t e;
    e = sb.pop_front();
    checks++;
    if (got_s() !== e.exp_s) begin
      failures++;
      $display("FAIL %s strobes got=%b exp=%b", tag, got_s(), e.exp_s);
    end
    checks++;
    if (bus.beat_cnt !== e.exp_bc) begin
      failures++;
      $display("FAIL %s beat_cnt got=%0d exp=%0d", tag, bus.beat_cnt, e.exp_bc);
    end
    checks++;
    if (bus.word_cnt !== e.exp_wc) begin
      failures++;
      $display("FAIL %s word_cnt got=%0d exp=%0d", tag, bus.word_cnt, e.exp_wc);
    end
  endtask

  // Called 1 time unit after a rising edge; returns at the same phase one cycle later.
  task automatic apply(input vec_t v);
    logic [31:0] c;
    c = $urandom;
    c[5:4] = v.bw;
    bus.csc      = c;
    bus.start    = v.start;
    bus.abort    = v.abort;
    bus.beat_ack = v.ack;
    bus.len      = v.len;
    sb.push_back(v);
    @(posedge clk);
    #1;
    check_outputs($sformatf("row%0d", row_id));
    row_id++;
  endtask

  task automatic idle_inputs();
    bus.csc = '0; bus.start = 1'b0; bus.abort = 1'b0; bus.beat_ack = 1'b0; bus.len = '0;
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if ({got_s(), bus.beat_cnt, bus.word_cnt} !== 12'h000) begin
      failures++;
      $display("FAIL %s reset outputs got=%b/%0d/%0d exp=0", tag, got_s(), bus.beat_cnt, bus.word_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    idle_inputs();
    bus.beat_ack = 1'b1;
    bus.start    = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_hold");
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // 8-bit, one word
    vecs.push_back(r(1,0,0,2'b00,3'd0,S_BUSY ,0,0));
    vecs.push_back(r(0,0,1,2'b00,3'd0,S_LE0  ,1,0));
    vecs.push_back(r(0,0,1,2'b00,3'd0,S_LE1  ,2,0));
    vecs.push_back(r(0,0,1,2'b00,3'd0,S_LE2  ,3,0));
    vecs.push_back(r(0,0,1,2'b00,3'd0,S_DONE ,0,1));
    vecs.push_back(r(0,0,0,2'b00,3'd0,S_IDLE ,0,1));
    // stray ack in IDLE
    vecs.push_back(r(0,0,1,2'b00,3'd0,S_STRAY,0,1));
    vecs.push_back(r(0,0,0,2'b00,3'd0,S_IDLE ,0,1));
    // 16-bit, three words, start while ACTIVE ignored (incl. final-beat cycle)
    vecs.push_back(r(1,0,0,2'b01,3'd2,S_BUSY ,0,0));
    vecs.push_back(r(0,0,0,2'b01,3'd2,S_BUSY ,0,0));
    vecs.push_back(r(0,0,1,2'b01,3'd2,S_LE0  ,1,0));
    vecs.push_back(r(0,0,1,2'b01,3'd2,S_DV   ,0,1));
    vecs.push_back(r(1,0,0,2'b00,3'd5,S_BUSY ,0,1));
    vecs.push_back(r(0,0,1,2'b01,3'd2,S_LE0  ,1,1));
    vecs.push_back(r(0,0,0,2'b01,3'd2,S_BUSY ,1,1));
    vecs.push_back(r(0,0,1,2'b01,3'd2,S_DV   ,0,2));
    vecs.push_back(r(0,0,1,2'b01,3'd2,S_LE0  ,1,2));
    vecs.push_back(r(1,0,1,2'b01,3'd2,S_DONE ,0,3));
    vecs.push_back(r(0,0,0,2'b01,3'd2,S_IDLE ,0,3));
    // 32-bit, eight words back-to-back; csc switches to 8-bit mid-sequence
    vecs.push_back(r(1,0,0,2'b10,3'd7,S_BUSY ,0,0));
    for (int k = 1; k <= 8; k++) begin
      vecs.push_back(r(0,0,1,(k > 3) ? 2'b00 : 2'b10,3'd7,(k == 8) ? S_DONE : S_DV,0,3'(k % 8)));
    end
    vecs.push_back(r(0,0,0,2'b00,3'd0,S_IDLE ,0,0));
    // reserved width behaves as 32-bit
    vecs.push_back(r(1,0,0,2'b11,3'd0,S_BUSY ,0,0));
    vecs.push_back(r(0,0,1,2'b11,3'd0,S_DONE ,0,1));
    // abort with the 3rd 8-bit beat, then abort+start, then a clean word
    vecs.push_back(r(1,0,0,2'b00,3'd0,S_BUSY ,0,0));
    vecs.push_back(r(0,0,1,2'b00,3'd0,S_LE0  ,1,0));
    vecs.push_back(r(0,0,1,2'b00,3'd0,S_LE1  ,2,0));
    vecs.push_back(r(0,1,1,2'b00,3'd0,S_IDLE ,0,0));
    vecs.push_back(r(0,0,0,2'b00,3'd0,S_IDLE ,0,0));
    vecs.push_back(r(1,1,0,2'b00,3'd0,S_IDLE ,0,0));
    vecs.push_back(r(0,0,0,2'b00,3'd0,S_IDLE ,0,0));
    vecs.push_back(r(1,0,0,2'b00,3'd0,S_BUSY ,0,0));
    vecs.push_back(r(0,0,1,2'b00,3'd0,S_LE0  ,1,0));
    vecs.push_back(r(0,0,1,2'b00,3'd0,S_LE1  ,2,0));
    vecs.push_back(r(0,0,1,2'b00,3'd0,S_LE2  ,3,0));
    vecs.push_back(r(0,0,1,2'b00,3'd0,S_DONE ,0,1));
    vecs.push_back(r(0,0,0,2'b00,3'd0,S_IDLE ,0,1));

    foreach (vecs[i]) apply(vecs[i]);

    // 16-bit, len=2, random idle gaps between beats
    apply(r(1,0,0,2'b01,3'd2,S_BUSY,0,0));
    for (int k = 0; k < 6; k++) begin
      int unsigned gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < int'(gap); g++)
        apply(r(0,0,0,2'b01,3'd2,S_BUSY,2'(k % 2),3'(k / 2)));
      apply(r(0,0,1,2'b01,3'd2,
              (k % 2 == 0) ? S_LE0 : ((k == 5) ? S_DONE : S_DV),
              (k % 2 == 0) ? 2'd1 : 2'd0, 3'((k + 1) / 2)));
    end
    apply(r(0,0,0,2'b01,3'd2,S_IDLE,0,3));

    // asynchronous reset in the middle of a 16-bit word
    apply(r(1,0,0,2'b01,3'd1,S_BUSY,0,0));
    apply(r(0,0,1,2'b01,3'd1,S_LE0 ,1,0));
    idle_inputs();
    bus.beat_ack = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_reset");
    @(negedge clk);
    bus.beat_ack = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    apply(r(0,0,0,2'b01,3'd1,S_IDLE,0,0));
    apply(r(0,0,0,2'b01,3'd1,S_IDLE,0,0));
    apply(r(1,0,0,2'b01,3'd0,S_BUSY,0,0));
    apply(r(0,0,1,2'b01,3'd0,S_LE0 ,1,0));
    apply(r(0,0,1,2'b01,3'd0,S_DONE,0,1));
    idle_inputs();

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
